// File: rtl/systolic_seq_2x2.sv
// Sequencer for a 2x2 systolic multiply array: loads a job, clears the array,
// feeds skewed A/B operands, runs until done or timeout, then hands back C.
module systolic_seq_2x2 #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [4*WIDTH-1:0] cmd_a,
  input  logic [4*WIDTH-1:0] cmd_b,
  input  logic               abort,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [4*WIDTH-1:0] res_c,
  output logic               res_err,
  output logic               busy,
  output logic [7:0]         arr_shift_n_flow,
  output logic [7:0]         arr_start,
  output logic [7:0]         arr_reset,
  output logic [WIDTH-1:0]   arr_west0,
  output logic [WIDTH-1:0]   arr_west1,
  output logic [WIDTH-1:0]   arr_north0,
  output logic [WIDTH-1:0]   arr_north1,
  input  logic               arr_done,
  input  logic [WIDTH-1:0]   arr_result0,
  input  logic [WIDTH-1:0]   arr_result1,
  input  logic [WIDTH-1:0]   arr_result2,
  input  logic [WIDTH-1:0]   arr_result3
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // The same counter sequences the 4 FILL phases, so it needs at least 2 bits.
  localparam int unsigned CW = (TW < 2) ? 2 : TW;

  typedef enum logic [2:0] {IDLE, CLR, FILL, RUN, OUT} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [4*WIDTH-1:0]  a_q;
  logic [4*WIDTH-1:0]  b_q;
  logic                aborted;
  logic                rst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      aborted <= 1'b0;
      rst_q   <= 1'b1;
      res_c   <= '0;
      res_err <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            aborted <= 1'b0;
            state   <= CLR;
          end
        end
        CLR: begin
          // An aborted job clears once more and returns to IDLE instead of FILL.
          if (abort) begin
            aborted <= 1'b1;
          end else if (aborted) begin
            state <= IDLE;
          end else begin
            cnt   <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (abort) begin
            aborted <= 1'b1;
            cnt     <= '0;
            state   <= CLR;
          end else if (cnt == CW'(3)) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            aborted <= 1'b1;
            cnt     <= '0;
            state   <= CLR;
          end else if (arr_done) begin
            res_c   <= {arr_result3, arr_result2, arr_result1, arr_result0};
            res_err <= 1'b0;
            cnt     <= '0;
            state   <= OUT;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            res_c   <= '0;
            res_err <= 1'b1;
            cnt     <= '0;
            state   <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = (state == OUT);

  always_comb begin
    arr_shift_n_flow = '0;
    arr_start        = '0;
    arr_reset        = '0;
    arr_west0        = '0;
    arr_west1        = '0;
    arr_north0       = '0;
    arr_north1       = '0;
    case (state)
      IDLE: arr_reset = rst_q ? 8'hFF : 8'h00;
      CLR:  arr_reset = 8'hFF;
      FILL: begin
        arr_shift_n_flow = 8'hF0;
        case (cnt[1:0])
          2'd0: begin
            arr_west0  = a_q[0*WIDTH +: WIDTH];
            arr_north0 = b_q[0*WIDTH +: WIDTH];
          end
          2'd1: begin
            arr_west0  = a_q[1*WIDTH +: WIDTH];
            arr_west1  = a_q[2*WIDTH +: WIDTH];
            arr_north0 = b_q[2*WIDTH +: WIDTH];
            arr_north1 = b_q[1*WIDTH +: WIDTH];
          end
          2'd2: begin
            arr_west1  = a_q[3*WIDTH +: WIDTH];
            arr_north1 = b_q[3*WIDTH +: WIDTH];
          end
          default: ;
        endcase
      end
      RUN: begin
        arr_shift_n_flow = 8'hF0;
        arr_start        = 8'h0F;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_seq_2x2.sv
// Randomized self-checking bench for systolic_seq_2x2 with a behavioural
// 2x2 array model that multiplies whatever skewed operands it is fed.
module tb_systolic_seq_2x2;
  localparam int W  = 16;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst, cmd_valid, cmd_ready, abort, res_valid, res_ready, res_err, busy;
  logic [4*W-1:0] cmd_a, cmd_b, res_c;
  logic [7:0]     arr_shift_n_flow, arr_start, arr_reset;
  logic [W-1:0]   arr_west0, arr_west1, arr_north0, arr_north1;
  logic           arr_done;
  logic [W-1:0]   arr_result0, arr_result1, arr_result2, arr_result3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_seq_2x2 #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .abort(abort), .res_valid(res_valid),
    .res_ready(res_ready), .res_c(res_c), .res_err(res_err), .busy(busy),
    .arr_shift_n_flow(arr_shift_n_flow), .arr_start(arr_start), .arr_reset(arr_reset),
    .arr_west0(arr_west0), .arr_west1(arr_west1), .arr_north0(arr_north0),
    .arr_north1(arr_north1), .arr_done(arr_done), .arr_result0(arr_result0),
    .arr_result1(arr_result1), .arr_result2(arr_result2), .arr_result3(arr_result3)
  );

  // Array model: captures one operand per buffer per FILL phase, then
  // forms C[i][j] = sum_t west_i[t+i] * north_j[t+j].
  logic [W-1:0] w0c [4];
  logic [W-1:0] w1c [4];
  logic [W-1:0] n0c [4];
  logic [W-1:0] n1c [4];
  int  fill_k  = 0;
  int  run_cnt = 0;
  bit  done_en = 1'b1;
  int  run_lat = 1;

  always @(posedge clk) begin
    if (arr_reset == 8'hFF) begin
      fill_k <= 0;
      for (int i = 0; i < 4; i++) begin
        w0c[i] <= '0; w1c[i] <= '0; n0c[i] <= '0; n1c[i] <= '0;
      end
    end else if (arr_shift_n_flow == 8'hF0 && arr_start == 8'h00 && fill_k < 4) begin
      w0c[fill_k] <= arr_west0;
      w1c[fill_k] <= arr_west1;
      n0c[fill_k] <= arr_north0;
      n1c[fill_k] <= arr_north1;
      fill_k      <= fill_k + 1;
    end
    run_cnt <= (arr_start == 8'h0F) ? run_cnt + 1 : 0;
  end

  assign arr_done    = done_en && (arr_start == 8'h0F) && (run_cnt == run_lat - 1);
  assign arr_result0 = W'(w0c[0] * n0c[0] + w0c[1] * n0c[1]);
  assign arr_result1 = W'(w0c[0] * n1c[1] + w0c[1] * n1c[2]);
  assign arr_result2 = W'(w1c[1] * n0c[0] + w1c[2] * n0c[1]);
  assign arr_result3 = W'(w1c[1] * n1c[1] + w1c[2] * n1c[2]);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] el(input logic [63:0] p, input int r, input int c);
    return p[(r*2+c)*W +: W];
  endfunction

  // Row i of A enters west_i skewed by i phases; column j of B enters north_j skewed by j.
  function automatic logic [W-1:0] west_exp(input logic [63:0] p, input int i, input int k);
    if (k - i < 0 || k - i > 1) return '0;
    return el(p, i, k - i);
  endfunction

  function automatic logic [W-1:0] north_exp(input logic [63:0] p, input int j, input int k);
    if (k - j < 0 || k - j > 1) return '0;
    return el(p, k - j, j);
  endfunction

  function automatic logic [63:0] matmul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        c[(i*2+j)*W +: W] = W'(el(a, i, 0) * el(b, 0, j) + el(a, i, 1) * el(b, 1, j));
    return c;
  endfunction

  function automatic logic [63:0] rand_mat();
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*W +: W] = W'($urandom_range(0, 15));
    return m;
  endfunction

  // Entered at a negedge with the DUT in IDLE; returns at the negedge of the IDLE cycle after the result handshake.
  task automatic run_job(input logic [63:0] pa, input logic [63:0] pb, input bit den,
                         input int lat, input int stall, input bit hold);
    int n;
    logic [63:0] expc;
    check("idle_ready", 64'(cmd_ready), 64'd1);
    cmd_a = pa; cmd_b = pb; cmd_valid = 1'b1;
    done_en = den; run_lat = lat;
    @(negedge clk);
    cmd_valid = hold;
    if (hold) begin cmd_a = ~pa; cmd_b = ~pb; end
    check("clr_reset", 64'(arr_reset), 64'hFF);
    check("clr_ctrl", 64'({arr_start, arr_shift_n_flow, cmd_ready, busy}), 64'h0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fill_ctrl", 64'({arr_reset, arr_start, arr_shift_n_flow}), 64'h0000F0);
      check("fill_w0", 64'(arr_west0),  64'(west_exp(pa, 0, k)));
      check("fill_w1", 64'(arr_west1),  64'(west_exp(pa, 1, k)));
      check("fill_n0", 64'(arr_north0), 64'(north_exp(pb, 0, k)));
      check("fill_n1", 64'(arr_north1), 64'(north_exp(pb, 1, k)));
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (res_valid) break;
      if (n == 0) begin
        check("run_ctrl", 64'({arr_reset, arr_start, arr_shift_n_flow}), 64'h000FF0);
        check("run_data", 64'({arr_west0, arr_west1, arr_north0, arr_north1}), 64'd0);
      end
      n++;
      if (n > TO + 4) begin
        check("res_valid_timeout", 64'd0, 64'd1);
        break;
      end
    end
    check("run_cycles", 64'(n), den ? 64'(lat) : 64'(TO));
    expc = den ? matmul(pa, pb) : 64'd0;
    check("res_c", res_c, expc);
    check("res_err", 64'(res_err), den ? 64'd0 : 64'd1);
    check("out_ctrl", 64'({arr_start, arr_shift_n_flow, res_valid, busy}), 64'h0003);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 64'(res_valid), 64'd1);
      check("stall_c", res_c, expc);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_after", 64'({cmd_ready, busy, res_valid}), 64'b100);
    check("res_hold", res_c, expc);
  endtask

  initial begin
    logic [63:0] ma, mb;
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0;
    repeat (2) @(negedge clk);
    check("rst_hs", 64'({cmd_ready, busy, res_valid, res_err}), 64'b1000);
    check("rst_c", res_c, 64'd0);
    check("rst_ctrl", 64'({arr_reset, arr_start, arr_shift_n_flow}), 64'hFF0000);
    check("rst_data", 64'({arr_west0, arr_west1, arr_north0, arr_north1}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arr_reset", 64'(arr_reset), 64'd0);

    // Reference product: 19, 22, 43, 50.
    run_job({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 3, 0, 1'b0);
    check("ref_c", res_c, {16'd50, 16'd43, 16'd22, 16'd19});
    // Identity times B, consumer stalled 5 cycles.
    run_job({16'd1, 16'd0, 16'd0, 16'd1}, {16'd6, 16'd7, 16'd8, 16'd9}, 1'b1, 2, 5, 1'b0);
    check("ident_c", res_c, {16'd6, 16'd7, 16'd8, 16'd9});
    // Array never finishes.
    run_job(rand_mat(), rand_mat(), 1'b0, 1, 1, 1'b0);

    // Abort during FILL phase 2.
    cmd_a = rand_mat(); cmd_b = rand_mat(); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_clr", 64'({arr_reset, busy, res_valid}), 64'({8'hFF, 2'b10}));
    @(negedge clk);
    check("abort_idle", 64'({cmd_ready, busy, res_valid, arr_reset}), 64'({3'b100, 8'h00}));
    run_job(rand_mat(), rand_mat(), 1'b1, 4, 0, 1'b0);

    // Reset during RUN with a stray command pending.
    cmd_a = rand_mat(); cmd_b = rand_mat(); cmd_valid = 1'b1; done_en = 1'b0;
    @(negedge clk);
    repeat (6) @(negedge clk);
    check("run_no_accept", 64'({cmd_ready, arr_start}), 64'({1'b0, 8'h0F}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    check("rst_run", 64'({cmd_ready, busy, res_valid, arr_start}), 64'({3'b100, 8'h00}));
    @(negedge clk);
    check("rst_run_idle", 64'({cmd_ready, res_valid, arr_reset}), 64'({2'b10, 8'h00}));

    // Back-to-back with cmd_valid held high across the first job.
    run_job(rand_mat(), rand_mat(), 1'b1, 2, 1, 1'b1);
    run_job(rand_mat(), rand_mat(), 1'b1, 5, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      ma = rand_mat(); mb = rand_mat();
      run_job(ma, mb, 1'b1, int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_seq_2x2.md
SYSTOLIC_SEQ_2X2 -- requirements
Module: systolic_seq_2x2

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result element width.
REQ-002 SHALL have parameter TIMEOUT, default 15: max RUN cycles waiting for arr_done.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1: reset is synchronous and active-high.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_a in 4*WIDTH, cmd_b in 4*WIDTH: job handshake; element order {x11,x10,x01,x00}, x00 at LSBs.
REQ-006 SHALL have port abort  in  1: cancels the current job.
REQ-007 SHALL have ports res_valid out 1, res_ready in 1, res_c out 4*WIDTH, res_err out 1: result handshake; res_c order {c11,c10,c01,c00}.
REQ-008 SHALL have port busy  out  1: high in every state except IDLE.
REQ-009 SHALL have ports arr_shift_n_flow out 8, arr_start out 8, arr_reset out 8: array control vectors.
REQ-010 SHALL have ports arr_west0, arr_west1, arr_north0, arr_north1  out  WIDTH each: array buffer inputs.
REQ-011 SHALL have ports arr_done in 1, arr_result0..3 in WIDTH each: array status and C00, C01, C10, C11.

Function
REQ-012 SHALL implement FSM states IDLE, CLR, FILL, RUN, OUT; array-side outputs are Moore, decoded from registered state and counter only.
REQ-013 SHALL assert cmd_ready only in IDLE; cmd_valid&cmd_ready registers cmd_a/cmd_b and moves to CLR; cmd_valid outside IDLE is ignored.
REQ-014 CLR SHALL last exactly 1 cycle with arr_reset=8'hFF, arr_start=0, arr_shift_n_flow=0, then FILL.
REQ-015 FILL SHALL last exactly 4 cycles (phase k=0..3) with arr_shift_n_flow=8'hF0, arr_start=0, arr_reset=0.
REQ-016 FILL data per phase k=0,1,2,3: west0 = A00,A01,0,0; west1 = 0,A10,A11,0; north0 = B00,B10,0,0; north1 = 0,B01,B11,0.
REQ-017 RUN SHALL drive arr_shift_n_flow=8'hF0, arr_start=8'h0F, arr_reset=0, all data outputs 0.
REQ-018 RUN SHALL exit to OUT on the first cycle arr_done=1, capturing arr_result0..3 into res_c that cycle with res_err=0.
REQ-019 RUN SHALL exit to OUT with res_err=1 and res_c=0 if arr_done is still 0 after TIMEOUT RUN cycles; counter width ceil(log2(TIMEOUT+1)).
REQ-020 OUT SHALL drive res_valid=1, arr_start=0, arr_shift_n_flow=0; res_c/res_err stable until res_valid&res_ready, then IDLE next cycle.
REQ-021 res_valid SHALL be 0 in all states other than OUT; res_c/res_err hold last value in IDLE.
REQ-022 abort=1 in CLR, FILL or RUN SHALL go to CLR next cycle, then IDLE (not FILL), no res_valid; abort in IDLE or OUT ignored.
REQ-023 abort and arr_done both 1 in RUN: abort wins.
REQ-024 Nominal latency accept -> res_valid: 1 (CLR) + 4 (FILL) + R (RUN cycles to arr_done) + 1.
REQ-025 Arithmetic is done in the array; block performs no arithmetic on data beyond selection/zeroing.

Reset
REQ-026 rst=1 SHALL force IDLE, counter 0, cmd_ready=1 next cycle, busy=0, res_valid=0, res_err=0, res_c=0, arr_reset=8'hFF (array cleared), arr_start=0, arr_shift_n_flow=0, data outputs 0.
REQ-027 rst mid-job SHALL discard the job without any res_valid pulse; rst outranks abort and all handshakes.
REQ-028 After rst deasserts, arr_reset SHALL be 0 in IDLE.

Verification
REQ-029 A=[[1,2],[3,4]], B=[[5,6],[7,8]] with real array -> res_c C00=19, C01=22, C10=43, C11=50, res_err=0; FILL data order per REQ-016 checked cycle by cycle.
REQ-030 A=identity, B=[[9,8],[7,6]] with res_ready low 5 cycles in OUT -> res_valid held, res_c stable {6,7,8,9}, IDLE one cycle after ready.
REQ-031 arr_done tied 0 -> exactly 15 RUN cycles, then res_valid=1, res_err=1, res_c=0.
REQ-032 abort at FILL phase 2 -> one CLR cycle with arr_reset=8'hFF, IDLE, no res_valid; next job returns correct result.
REQ-033 rst asserted in RUN -> next cycle IDLE, arr_start=0, busy=0, no res_valid; cmd_valid held during RUN beforehand not accepted.
REQ-034 Back-to-back jobs with cmd_valid held high -> second accepted in IDLE cycle after first handshake; both results correct.
